cntr8_cmd_seq: RTL and testbench
================================

Name: cntr8_cmd_seq

Overview:
- Upstream command sequencer for the 8-bit counter block.
- Accepts queued commands over a valid/ready interface and expands each into a cycle-exact load/inc/d_in drive sequence on the counter's control inputs.
- Decouples software/testbench command issue from counter timing; buffers up to DEPTH commands.

Parameters:
DEPTH, 4, command FIFO entries; power of two, >= 2
DW, 8, data width of cmd_data and d_in

Ports:
clk        input   1      system clock, rising edge
reset_n    input   1      asynchronous active-low reset
cmd_valid  input   1      command present
cmd_ready  output  1      FIFO can accept; handshake when cmd_valid & cmd_ready
cmd_op     input   2      00 NOP, 01 LOAD, 10 INC_N, 11 WAIT_N
cmd_data   input   DW     LOAD value, or repeat count N for INC_N/WAIT_N
abort      input   1      synchronous flush of FIFO and current command
load       output  1      load strobe to counter
inc        output  1      increment enable to counter
d_in       output  DW     load value to counter
busy       output  1      FSM not IDLE or FIFO non-empty

Behaviour:
- Reset (async, reset_n=0): FIFO empty, FSM=IDLE, load=0, inc=0, d_in=0, busy=0, cmd_ready=0 while reset_n low.
- cmd_ready = !fifo_full & !abort. Push when cmd_valid & cmd_ready.
- All drive outputs are registered; no combinational path from cmd_* to load/inc/d_in.
- FSM states: IDLE, LOAD, RUN, WAIT.
- IDLE: if FIFO non-empty, pop the head entry and branch on op:
  - NOP -> stay IDLE; entry consumed.
  - LOAD -> LOAD; d_in <= data.
  - INC_N, N>0 -> RUN; cnt <= N.
  - WAIT_N, N>0 -> WAIT; cnt <= N.
  - INC_N/WAIT_N with N=0 -> treated as NOP.
- LOAD: load=1 for exactly one cycle, then IDLE.
- RUN: inc=1 each cycle, cnt decrements; leave to IDLE after N cycles of inc=1.
- WAIT: load=inc=0 for N cycles, then IDLE.
- IDLE always lasts >= 1 cycle between commands, so consecutive commands are separated by one cycle with load=inc=0.
- Latency: handshake in cycle k into an empty FIFO with FSM in IDLE -> first load/inc high in cycle k+2.
- d_in holds the last LOAD value indefinitely; only LOAD changes it.
- Full FIFO: cmd_ready=0. A pop while full raises cmd_ready the next cycle; no same-cycle push-on-pop.
- Empty FIFO: IDLE holds, outputs low, busy=0.
- Simultaneous push and pop at non-full, non-empty: both take effect; occupancy unchanged.
- abort=1 (sampled at edge):
  - FIFO emptied, FSM -> IDLE, load=inc=0 next cycle, cnt cleared; d_in retained.
  - Any push in the abort cycle is discarded (cmd_ready=0).
- Reset mid-command: immediate return to reset values; the pending command is lost.
- Counter N is DW bits; max 255 cycles per command for DW=8. No wrap: cnt stops at 0.

Optional Feature:
CNTR8_CMD_SEQ_STATS_EN
- Defined: adds output done_cnt [7:0].
  - Increments by 1 on each completed LOAD, INC_N or WAIT_N command (including N=0 and NOP drops? no: only non-NOP commands with N>0).
  - Saturates at 255.
  - Cleared by reset and by abort.
- Not defined: port absent, no stats logic.

Decomposition:
- Package cntr8_cmd_pkg holds:
  - op encodings: OP_NOP, OP_LOAD, OP_INC_N, OP_WAIT_N
  - FSM state enum: IDLE, LOAD, RUN, WAIT
- Sub-module cmd_fifo: synchronous FIFO parameterised by DEPTH and width (2+DW). Ports: push, pop, din, dout, full, empty, flush.

Test Plan:
- Reset then push LOAD 0x5A in cycle 3 -> load=1 only in cycle 5, d_in=0x5A from cycle 5 onward, busy drops after cycle 5.
- Push INC_N 3 immediately followed by LOAD 0x10 -> inc high exactly 3 cycles, one idle cycle, then load pulse with d_in=0x10.
- Push 5 commands back-to-back with DEPTH=4 and FSM stalled in WAIT_N 20 -> cmd_ready low after the 4th push; 5th accepted only after the first pop; no command lost or duplicated.
- INC_N 0 and NOP interleaved with LOAD 0x01 -> no inc pulses; one load pulse only.
- abort asserted mid INC_N 10 (after 4 incs) with 2 entries queued -> inc low next cycle, FIFO empty, busy=0, d_in unchanged; with STATS_EN, done_cnt=0.
- reset_n asserted low mid WAIT_N 8 asynchronously -> all outputs reset immediately; the first command after release behaves as in a fresh reset.

Source files
------------

// File: rtl/cntr8_cmd_seq_pkg.sv
// Shared op encodings and FSM state constants for the counter command sequencer.
// Purely declarative; no logic, latency or backpressure of its own.
package cntr8_cmd_pkg;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_INC_N  = 2'b10;
  localparam logic [1:0] OP_WAIT_N = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t LOAD = 2'd1;
  localparam state_t RUN  = 2'd2;
  localparam state_t WAIT = 2'd3;

endpackage

// File: rtl/cntr8_cmd_seq_if.sv
// Command valid/ready bus into the sequencer; master issues, slave accepts.
// Transfer happens on any edge where cmd_valid and cmd_ready are both high.
interface cntr8_cmd_seq_if #(
  parameter int DW = 8
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [DW-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/cntr8_cmd_seq_fifo.sv
// Synchronous FIFO, combinational head read; push ignored when full, pop when empty.
// One-cycle write-to-visible latency; flush empties it at the next edge.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/cntr8_cmd_seq.sv
// Expands queued LOAD/INC_N/WAIT_N commands into registered load/inc/d_in drive; first strobe 2 cycles after handshake.
// cmd_ready drops when the FIFO is full or abort is high; CNTR8_CMD_SEQ_STATS_EN adds the done_cnt output.
module cntr8_cmd_seq
  import cntr8_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  cntr8_cmd_seq_if.slave cmd,
  input  logic          abort,
  output logic          load,
  output logic          inc,
  output logic [DW-1:0] d_in,
  output logic          busy
`ifdef CNTR8_CMD_SEQ_STATS_EN
  ,
  output logic [7:0]    done_cnt
`endif
);
  localparam logic [DW-1:0] ONE = 1;

  state_t        state;
  logic [DW-1:0] cnt;
  logic          fifo_full, fifo_empty;
  logic          push, pop;
  logic [DW+1:0] head;
  logic [1:0]    head_op;
  logic [DW-1:0] head_n;
  logic          last_tick;

  assign cmd.cmd_ready = reset_n & ~fifo_full & ~abort;
  assign push          = cmd.cmd_valid & cmd.cmd_ready;
  assign pop           = (state == IDLE) & ~fifo_empty & ~abort;
  assign head_op       = head[DW+1:DW];
  assign head_n        = head[DW-1:0];
  assign busy          = (state != IDLE) | ~fifo_empty;
  assign last_tick     = (cnt == ONE) || (cnt == '0);

  cmd_fifo #(.DEPTH(DEPTH), .W(DW + 2)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (abort),
    .din     ({cmd.cmd_op, cmd.cmd_data}),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      load  <= 1'b0;
      inc   <= 1'b0;
      d_in  <= '0;
    end else if (abort) begin
      state <= IDLE;
      cnt   <= '0;
      load  <= 1'b0;
      inc   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          load <= 1'b0;
          inc  <= 1'b0;
          // Zero-count INC_N/WAIT_N fall through and are consumed like NOP.
          if (!fifo_empty) begin
            case (head_op)
              OP_LOAD: begin
                state <= LOAD;
                d_in  <= head_n;
                load  <= 1'b1;
              end
              OP_INC_N: if (head_n != '0) begin
                state <= RUN;
                cnt   <= head_n;
                inc   <= 1'b1;
              end
              OP_WAIT_N: if (head_n != '0) begin
                state <= WAIT;
                cnt   <= head_n;
              end
              default: state <= IDLE;
            endcase
          end
        end
        LOAD: begin
          load  <= 1'b0;
          state <= IDLE;
        end
        RUN, WAIT: begin
          if (last_tick) begin
            inc   <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CNTR8_CMD_SEQ_STATS_EN
  logic cmd_done;
  assign cmd_done = (state == LOAD) || (((state == RUN) || (state == WAIT)) && last_tick);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_cnt <= 8'd0;
    end else if (abort) begin
      done_cnt <= 8'd0;
    end else if (cmd_done && (done_cnt != 8'hFF)) begin
      done_cnt <= done_cnt + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cntr8_cmd_seq.sv
// Directed bench for cntr8_cmd_seq: latency, back-to-back, full FIFO, zero-count, abort, mid-command reset.
module tb_cntr8_cmd_seq;
  import cntr8_cmd_pkg::*;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          abort = 1'b0;
  logic          load, inc, busy;
  logic [DW-1:0] d_in;
`ifdef CNTR8_CMD_SEQ_STATS_EN
  logic [7:0]    done_cnt;
`endif

  cntr8_cmd_seq_if #(.DW(DW)) cmd_if ();

  cntr8_cmd_seq #(.DEPTH(4), .DW(DW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cmd      (cmd_if),
    .abort    (abort),
    .load     (load),
    .inc      (inc),
    .d_in     (d_in),
    .busy     (busy)
`ifdef CNTR8_CMD_SEQ_STATS_EN
    ,
    .done_cnt (done_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int load_cnt = 0;
  int inc_cnt  = 0;
  int last_wait = 0;
  logic [7:0] load_log[$];

  always @(negedge clk) begin
    if (reset_n) begin
      if (load) begin
        load_cnt++;
        load_log.push_back(d_in);
      end
      if (inc) inc_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    load_cnt = 0;
    inc_cnt  = 0;
    load_log.delete();
  endtask

  // Returns just after the handshake edge.
  task automatic push(input logic [1:0] op, input logic [7:0] data);
    int n;
    n = 0;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = data;
    while (!cmd_if.cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("push_ready", cmd_if.cmd_ready, 1);
    last_wait = n;
    @(posedge clk);
    #1 cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || load || inc) && n < lim);
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic load_lat(input string tag, input logic [7:0] data);
    push(OP_LOAD, data);
    @(negedge clk);
    chk({tag, "_k1_load"}, load, 0);
    chk({tag, "_k1_busy"}, busy, 1);
    @(negedge clk);
    chk({tag, "_k2_load"}, load, 1);
    chk({tag, "_k2_din"}, d_in, data);
    @(negedge clk);
    chk({tag, "_k3_load"}, load, 0);
    chk({tag, "_k3_busy"}, busy, 0);
    chk({tag, "_k3_din"}, d_in, data);
`ifdef CNTR8_CMD_SEQ_STATS_EN
    chk({tag, "_done"}, done_cnt, 1);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] iv, lv, dv;
    logic [7:0] exp_log [5];

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_NOP;
    cmd_if.cmd_data  = '0;

    #2;
    chk("rst_load", load, 0);
    chk("rst_inc", inc, 0);
    chk("rst_din", d_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_if.cmd_ready, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    load_lat("lat", 8'h5A);

    // INC_N 3 then LOAD 0x10 back-to-back.
    clr_mon();
    push(OP_INC_N, 8'd3);
    push(OP_LOAD, 8'h10);
    iv = '0; lv = '0; dv = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      iv[i] = inc;
      lv[i] = load;
      if (load) dv = d_in;
    end
    chk("b2b_inc_pat", iv, 8'h07);
    chk("b2b_load_pat", lv, 8'h10);
    chk("b2b_din", dv, 8'h10);
    wait_idle("b2b", 50);
`ifdef CNTR8_CMD_SEQ_STATS_EN
    chk("b2b_done", done_cnt, 3);
`endif

    // Fill FIFO behind a long WAIT_N.
    clr_mon();
    push(OP_WAIT_N, 8'd20);
    push(OP_LOAD, 8'h21);
    push(OP_LOAD, 8'h22);
    push(OP_LOAD, 8'h23);
    push(OP_LOAD, 8'h24);
    @(negedge clk);
    chk("full_ready", cmd_if.cmd_ready, 0);
    chk("full_busy", busy, 1);
    push(OP_LOAD, 8'h25);
    chk("full_wait", last_wait, 17);
    wait_idle("full", 100);
    chk("full_loads", load_cnt, 5);
    exp_log = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25};
    for (int i = 0; i < 5; i++) chk($sformatf("full_order%0d", i), load_log[i], exp_log[i]);
    chk("full_din", d_in, 8'h25);
    chk("full_incs", inc_cnt, 0);
`ifdef CNTR8_CMD_SEQ_STATS_EN
    chk("full_done", done_cnt, 9);
`endif

    // Zero-count commands and NOP are consumed silently.
    clr_mon();
    push(OP_NOP, 8'hFF);
    push(OP_INC_N, 8'd0);
    push(OP_LOAD, 8'h01);
    push(OP_INC_N, 8'd0);
    push(OP_WAIT_N, 8'd0);
    wait_idle("nop", 50);
    chk("nop_incs", inc_cnt, 0);
    chk("nop_loads", load_cnt, 1);
    chk("nop_din", d_in, 8'h01);
`ifdef CNTR8_CMD_SEQ_STATS_EN
    chk("nop_done", done_cnt, 10);
`endif

    // Abort after four incs with two LOADs queued; a push in the abort cycle is dropped.
    clr_mon();
    push(OP_INC_N, 8'd10);
    push(OP_LOAD, 8'h77);
    push(OP_LOAD, 8'h78);
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        #1;
        n++;
      end while (inc_cnt < 4 && n < 50);
    end
    abort = 1'b1;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = OP_LOAD;
    cmd_if.cmd_data  = 8'h99;
    #1;
    chk("abort_ready", cmd_if.cmd_ready, 0);
    @(posedge clk);
    #1;
    abort = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_inc", inc, 0);
    chk("abort_load", load, 0);
    chk("abort_busy", busy, 0);
    chk("abort_din", d_in, 8'h01);
`ifdef CNTR8_CMD_SEQ_STATS_EN
    chk("abort_done", done_cnt, 0);
`endif
    repeat (15) @(negedge clk);
    @(posedge clk);
    chk("abort_incs", inc_cnt, 4);
    chk("abort_loads", load_cnt, 0);

    // Asynchronous reset in the middle of WAIT_N 8.
    push(OP_WAIT_N, 8'd8);
    repeat (3) @(negedge clk);
    chk("rst2_pre_busy", busy, 1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst2_busy", busy, 0);
    chk("rst2_din", d_in, 0);
    chk("rst2_load", load, 0);
    chk("rst2_inc", inc, 0);
    chk("rst2_ready", cmd_if.cmd_ready, 0);
    @(negedge clk);
    reset_n = 1'b1;
    load_lat("rst2", 8'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
